// File: rtl/srl_cam_update_ctrl.sv
// ---------------------------------------------------------------------------
// srl_cam_update_ctrl
//
// Purpose:
//   Sequences rule writes into the SRL32-based fractional CAM array. An
//   accepted write/invalidate command first waits for the lookup pipeline to
//   drain, then drives a 32-cycle serial shift into one entry column. Every
//   5-bit key slice gets its own serial data bit, so after the shift, SRL tap
//   a of slice s holds "slice value a matches this rule". Lookups are held
//   off from the moment an update is accepted until it has completed. This
//   keeps lookups from seeing a half-written column.
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-low reset
//   upd_valid     update command valid
//   upd_ready     command accepted when upd_valid & upd_ready (IDLE only)
//   upd_op        1 = write rule, 0 = invalidate entry
//   upd_addr      target entry
//   upd_key       rule key
//   upd_mask      ternary mask, 1 = don't care
//   upd_done      one-cycle pulse when the update completes
//   lookup_valid  lookup request from the search port
//   lookup_ready  lookup may enter the CAM this cycle
//   srl_we        shift enable for the addressed column
//   srl_addr      column being written
//   srl_din       serial data bit per key slice
//   busy          high in any state other than IDLE
//
// Optional feature (macro FRACTCAM_VALID_MAP_EN):
//   entry_valid   per-entry valid map, cleared on accept, set to the op in DONE
//   cam_full      registered AND of entry_valid
// ---------------------------------------------------------------------------
module srl_cam_update_ctrl #(
    parameter int KEY_WIDTH  = 40,
    parameter int ADDR_WIDTH = 5,
    parameter int LOOKUP_LAT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic                        upd_op,
    input  logic [ADDR_WIDTH-1:0]       upd_addr,
    input  logic [KEY_WIDTH-1:0]        upd_key,
    input  logic [KEY_WIDTH-1:0]        upd_mask,
    output logic                        upd_done,
    input  logic                        lookup_valid,
    output logic                        lookup_ready,
    output logic                        srl_we,
    output logic [ADDR_WIDTH-1:0]       srl_addr,
    output logic [KEY_WIDTH/5-1:0]      srl_din,
`ifdef FRACTCAM_VALID_MAP_EN
    output logic [(1<<ADDR_WIDTH)-1:0]  entry_valid,
    output logic                        cam_full,
`endif
    output logic                        busy
);

    localparam int N_SLICES = KEY_WIDTH / 5;
    localparam int DRAIN_W  = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [4:0]             shift_cnt;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   op_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [KEY_WIDTH-1:0]   mask_q;

    // The lookup gate only depends on the update side. lookup_valid is part
    // of the search-port handshake, but it never changes what this block does.
    logic unused_lookup_valid;
    assign unused_lookup_valid = lookup_valid;

    // Serial data for one shift cycle. Slice s matches value v when every
    // unmasked bit of v equals the key bit. Invalidates shift in all zeros,
    // so no slice value can ever hit the column.
    function automatic logic [N_SLICES-1:0] slice_match(
        input logic                 op,
        input logic [KEY_WIDTH-1:0] key,
        input logic [KEY_WIDTH-1:0] mask,
        input logic [4:0]           v
    );
        logic [N_SLICES-1:0] bits;
        bits = '0;
        for (int s = 0; s < N_SLICES; s++) begin
            bits[s] = op && (((v ^ key[5*s +: 5]) & ~mask[5*s +: 5]) == 5'd0);
        end
        return bits;
    endfunction

    // Handshakes are decoded straight from the state. In IDLE an update has
    // priority over a lookup that arrives in the same cycle. The lookup is
    // therefore refused as soon as upd_valid is seen.
    assign upd_ready    = (state == IDLE);
    assign lookup_ready = (state == IDLE) && !upd_valid;
    assign busy         = (state != IDLE);

    // Main sequencer. The SRL-facing outputs are registered and are loaded
    // on the same edge that enters the state they belong to. So the first
    // shift beat already shows v = 31 on the first SHIFT cycle. shift_cnt
    // always holds the v of the beat currently on srl_din. It rests at 31
    // between updates, so each shift starts from the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_cnt <= 5'd31;
            drain_cnt <= '0;
            op_q      <= 1'b0;
            addr_q    <= '0;
            key_q     <= '0;
            mask_q    <= '0;
            srl_we    <= 1'b0;
            srl_addr  <= '0;
            srl_din   <= '0;
            upd_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (upd_valid) begin
                        op_q   <= upd_op;
                        addr_q <= upd_addr;
                        key_q  <= upd_key;
                        mask_q <= upd_mask;
                        if (LOOKUP_LAT > 0) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_W'(LOOKUP_LAT - 1);
                        end else begin
                            state    <= SHIFT;
                            srl_we   <= 1'b1;
                            srl_addr <= upd_addr;
                            srl_din  <= slice_match(upd_op, upd_key, upd_mask, 5'd31);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= SHIFT;
                        srl_we   <= 1'b1;
                        srl_addr <= addr_q;
                        srl_din  <= slice_match(op_q, key_q, mask_q, 5'd31);
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                SHIFT: begin
                    if (shift_cnt == 5'd0) begin
                        state     <= DONE;
                        shift_cnt <= 5'd31;
                        srl_we    <= 1'b0;
                        srl_din   <= '0;
                        upd_done  <= 1'b1;
                    end else begin
                        shift_cnt <= shift_cnt - 5'd1;
                        srl_din   <= slice_match(op_q, key_q, mask_q, shift_cnt - 5'd1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    upd_done <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FRACTCAM_VALID_MAP_EN
    logic accept;
    assign accept = (state == IDLE) && upd_valid;

    // Valid map. An entry goes invalid when an update for it is accepted. It
    // only becomes valid again in DONE, so a write cut short by reset leaves
    // the entry invalid. cam_full samples the map one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_valid <= '0;
            cam_full    <= 1'b0;
        end else begin
            if (accept) begin
                entry_valid[upd_addr] <= 1'b0;
            end
            if (state == DONE) begin
                entry_valid[addr_q] <= op_q;
            end
            cam_full <= &entry_valid;
        end
    end
`endif

endmodule

// File: tb/tb_srl_cam_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_srl_cam_update_ctrl
//
// Drives directed and random update commands into srl_cam_update_ctrl. For
// each command it pushes the expected shift beats, the done pulse, the busy
// window and the valid-map events into queues, keyed by cycle number. A
// monitor process checks the DUT outputs against those queues on every
// falling edge. The expected beat data comes from a per-bit matching model
// of the ternary slice rule.
// ---------------------------------------------------------------------------
module tb_srl_cam_update_ctrl;

    localparam int KW  = 40;
    localparam int AW  = 5;
    localparam int LAT = 2;
    localparam int NS  = KW / 5;
    localparam int NE  = 1 << AW;

    logic           clk = 1'b0;
    logic           reset;
    logic           upd_valid;
    logic           upd_ready;
    logic           upd_op;
    logic [AW-1:0]  upd_addr;
    logic [KW-1:0]  upd_key;
    logic [KW-1:0]  upd_mask;
    logic           upd_done;
    logic           lookup_valid;
    logic           lookup_ready;
    logic           srl_we;
    logic [AW-1:0]  srl_addr;
    logic [NS-1:0]  srl_din;
    logic           busy;
`ifdef FRACTCAM_VALID_MAP_EN
    logic [NE-1:0]  entry_valid;
    logic           cam_full;
`endif

    srl_cam_update_ctrl #(
        .KEY_WIDTH  (KW),
        .ADDR_WIDTH (AW),
        .LOOKUP_LAT (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_op       (upd_op),
        .upd_addr     (upd_addr),
        .upd_key      (upd_key),
        .upd_mask     (upd_mask),
        .upd_done     (upd_done),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .srl_we       (srl_we),
        .srl_addr     (srl_addr),
        .srl_din      (srl_din),
`ifdef FRACTCAM_VALID_MAP_EN
        .entry_valid  (entry_valid),
        .cam_full     (cam_full),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Cycle number. Cycle k is the interval that starts at the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    int free_cyc = 0;

    typedef struct { int cyc; logic [AW-1:0] addr; logic [NS-1:0] din; } beat_t;
    typedef struct { int lo; int hi; } win_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic op; } vm_t;

    beat_t beat_q[$];
    int    done_q[$];
    win_t  win_q[$];
    vm_t   clr_q[$];
    vm_t   set_q[$];

    logic [NE-1:0] ev_exp = '0;
    logic          full_exp = 1'b0;

    function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // Reference rule: slice s matches value v when each bit of v either is
    // masked off or equals the corresponding key bit. Invalidates never match.
    function automatic logic [NS-1:0] refBitmap(input logic op, input logic [KW-1:0] key,
                                                input logic [KW-1:0] mask, input int v);
        logic [NS-1:0] r;
        logic [4:0]    vb;
        bit            hit;
        vb = 5'(v);
        r  = '0;
        for (int s = 0; s < NS; s++) begin
            hit = (op == 1'b1);
            for (int b = 0; b < 5; b++) begin
                if (mask[5*s+b] == 1'b0 && vb[b] != key[5*s+b]) hit = 1'b0;
            end
            r[s] = hit;
        end
        return r;
    endfunction

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command. It is held until the first cycle the model
    // considers the DUT idle, and the expected response is queued up front.
    task automatic applyStimulus(input logic op, input logic [AW-1:0] addr,
                                 input logic [KW-1:0] key, input logic [KW-1:0] mask);
        int          t;
        beat_t       b;
        win_t        w;
        vm_t         m;
        logic [63:0] r;
        t = (cyc >= free_cyc) ? cyc : free_cyc;
        upd_valid = 1'b1;
        upd_op    = op;
        upd_addr  = addr;
        upd_key   = key;
        upd_mask  = mask;
        for (int i = 0; i < 32; i++) begin
            b.cyc  = t + 1 + LAT + i;
            b.addr = addr;
            b.din  = refBitmap(op, key, mask, 31 - i);
            beat_q.push_back(b);
        end
        done_q.push_back(t + 33 + LAT);
        w.lo = t + 1;
        w.hi = t + 33 + LAT;
        win_q.push_back(w);
        m.cyc  = t;
        m.addr = addr;
        m.op   = op;
        clr_q.push_back(m);
        m.cyc = t + 33 + LAT;
        set_q.push_back(m);
        free_cyc = t + 34 + LAT;
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        r = {$urandom, $urandom};
        upd_key  = r[KW-1:0];
        r = {$urandom, $urandom};
        upd_mask = r[KW-1:0];
        upd_op   = 1'($urandom_range(0, 1));
        upd_addr = AW'($urandom);
    endtask

    // Pull reset low partway through a shift. Every output must drop at once,
    // without waiting for a clock edge.
    task automatic applyResetMidShift(input int beat);
        int target;
        target = cyc + LAT + beat;
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        checkOutput("rst_srl_we", srl_we, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_srl_din", srl_din, '0);
        checkOutput("rst_upd_done", upd_done, 1'b0);
        checkOutput("rst_upd_ready", upd_ready, 1'b1);
        checkOutput("rst_lookup_ready", lookup_ready, !upd_valid);
`ifdef FRACTCAM_VALID_MAP_EN
        checkOutput("rst_entry_valid", entry_valid, '0);
        checkOutput("rst_cam_full", cam_full, 1'b0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        beat_q.delete();
        done_q.delete();
        win_q.delete();
        clr_q.delete();
        set_q.delete();
        ev_exp   = '0;
        full_exp = 1'b0;
        free_cyc = cyc;
        mon_en   = 1'b1;
    endtask

    // Random lookup traffic. It only matters for the lookup_ready priority rule.
    initial begin
        lookup_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            lookup_valid = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compares every output on each falling edge against the
    // expectations that were queued for this cycle number.
    initial begin
        bit   idle_exp;
        bit   we_exp;
        bit   done_exp;
        logic full_next;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (win_q.size() > 0 && win_q[0].hi < cyc) void'(win_q.pop_front());
                idle_exp = !(win_q.size() > 0 && cyc >= win_q[0].lo);
                checkOutput("busy", busy, !idle_exp);
                checkOutput("upd_ready", upd_ready, idle_exp);
                checkOutput("lookup_ready", lookup_ready, idle_exp && !upd_valid);
                we_exp = (beat_q.size() > 0 && beat_q[0].cyc == cyc);
                checkOutput("srl_we", srl_we, we_exp);
                if (we_exp) begin
                    checkOutput("srl_addr", srl_addr, beat_q[0].addr);
                    checkOutput("srl_din", srl_din, beat_q[0].din);
                    void'(beat_q.pop_front());
                end
                done_exp = (done_q.size() > 0 && done_q[0] == cyc);
                checkOutput("upd_done", upd_done, done_exp);
                if (done_exp) void'(done_q.pop_front());
`ifdef FRACTCAM_VALID_MAP_EN
                checkOutput("entry_valid", entry_valid, ev_exp);
                checkOutput("cam_full", cam_full, full_exp);
`endif
                full_next = &ev_exp;
                if (clr_q.size() > 0 && clr_q[0].cyc == cyc) begin
                    ev_exp[clr_q[0].addr] = 1'b0;
                    void'(clr_q.pop_front());
                end
                if (set_q.size() > 0 && set_q[0].cyc == cyc) begin
                    ev_exp[set_q[0].addr] = set_q[0].op;
                    void'(set_q.pop_front());
                end
                full_exp = full_next;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] r1;
        logic [63:0] r2;
        logic [63:0] r3;
        reset     = 1'b0;
        upd_valid = 1'b0;
        upd_op    = 1'b0;
        upd_addr  = '0;
        upd_key   = '0;
        upd_mask  = '0;
        #1;
        checkOutput("reset_srl_we", srl_we, 1'b0);
        checkOutput("reset_srl_addr", srl_addr, '0);
        checkOutput("reset_busy", busy, 1'b0);
        idleCycles(3);
        reset    = 1'b1;
        free_cyc = cyc;
        mon_en   = 1'b1;
        idleCycles(2);

        // Single-slice exact key, then a ternary slice with others don't-care.
        applyStimulus(1'b1, AW'(3), 40'h00_0000_0005, 40'h0);
        idleCycles(5);
        applyStimulus(1'b1, AW'(0), 40'h00_0000_0012, 40'hFF_FFFF_FFE3);
        // Issued while still busy: the command must be held, then taken.
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        applyStimulus(1'b0, AW'(7), r1[KW-1:0], r2[KW-1:0]);
        idleCycles(40);

        // Reset in the middle of a write.
        applyStimulus(1'b1, AW'(9), 40'h12_3456_789A, 40'h0);
        applyResetMidShift(10);
        idleCycles(3);

        // Random commands with random gaps (including zero, which tests holding).
        for (int i = 0; i < 30; i++) begin
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            r3 = {$urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 3) != 0), AW'($urandom),
                          r1[KW-1:0], r2[KW-1:0] & r3[KW-1:0]);
            idleCycles($urandom_range(0, 45));
        end

`ifdef FRACTCAM_VALID_MAP_EN
        // Fill every entry so cam_full rises, then knock one entry out.
        for (int a = 0; a < NE; a++) begin
            r1 = {$urandom, $urandom};
            applyStimulus(1'b1, AW'(a), r1[KW-1:0], 40'h0);
        end
        idleCycles(40);
        applyStimulus(1'b0, AW'(2), 40'h0, 40'h0);
        idleCycles(5);
`endif

        for (int i = 0; i < 400 && (beat_q.size() > 0 || done_q.size() > 0); i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pending_expectations", 64'(beat_q.size() + done_q.size()), 64'd0);
        idleCycles(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
